single_port_ram_multi_byte: RTL and testbench

//  Parametrised single-port RAM, NUM_BYTES byte lanes wide, with per-lane write enables.

---
 rtl/single_port_ram_multi_byte.sv | 266 ++++++++++++++++++++++++++
 tb/tb_single_port_ram_multi_byte.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/single_port_ram_multi_byte.sv
// -----------------------------------------------------------------------------
// single_port_ram_multi_byte
//
// Single-port RAM made of NUM_BYTES byte lanes, with a write enable per lane.
// It sits between the MCU memory-bus mux and the on-chip block RAM.
// After reset an init sequencer writes FILL_BYTE to every lane of every word,
// one word per cycle. During that time ready is low. After the fill the RAM
// accepts one request per cycle through a req/ack handshake.
//
// Optional feature macro: RAM_PARITY_EN
//   When defined, each lane stores an even-parity bit. A read ack reports a
//   per-lane parity mismatch on parity_err.
//
// Parameters
//   ADDR_WIDTH  word address width, DEPTH = 2**ADDR_WIDTH
//   NUM_BYTES   byte lanes per word, data width DW = 8*NUM_BYTES
//   OUT_REG     0: ack/dout 1 cycle after accept, 1: 2 cycles after accept
//   INIT_FILL   1: fill memory after reset, 0: skip the fill
//   FILL_BYTE   value written to each lane during the fill
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   req         access request, taken when ready=1
//   we          1 = write, 0 = read
//   be          per-lane write enables (ignored for reads)
//   addr        word address
//   din         write data, lane k = din[8k+7:8k]
//   ready       a request is accepted this cycle
//   ack         one-cycle completion pulse, one per accepted request
//   dout        read data, valid with ack of a read, held otherwise
//   init_done   fill complete, stays high until reset
//   parity_err  (RAM_PARITY_EN) per-lane parity mismatch, aligned with ack
// -----------------------------------------------------------------------------
module single_port_ram_multi_byte #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          NUM_BYTES  = 4,
  parameter int          OUT_REG    = 0,
  parameter int          INIT_FILL  = 1,
  parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      we,
  input  logic [NUM_BYTES-1:0]      be,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [8*NUM_BYTES-1:0]    din,
  output logic                      ready,
  output logic                      ack,
  output logic [8*NUM_BYTES-1:0]    dout,
  output logic                      init_done
`ifdef RAM_PARITY_EN
  ,
  output logic [NUM_BYTES-1:0]      parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int DW    = 8 * NUM_BYTES;
`ifdef RAM_PARITY_EN
  localparam int MW    = 9 * NUM_BYTES;
`else
  localparam int MW    = DW;
`endif
  localparam logic [ADDR_WIDTH:0] LAST_ICNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ICNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Data lanes occupy the low DW bits. The parity bit of lane k, when present,
  // sits at bit DW+k.
  function automatic logic [MW-1:0] encode_word(input logic [DW-1:0] d);
    logic [MW-1:0] w;
    w = '0;
    w[DW-1:0] = d;
`ifdef RAM_PARITY_EN
    for (int k = 0; k < NUM_BYTES; k++) begin
      w[DW+k] = ^d[8*k +: 8];
    end
`endif
    return w;
  endfunction

`ifdef RAM_PARITY_EN
  function automatic logic [NUM_BYTES-1:0] parity_check(input logic [MW-1:0] w);
    logic [NUM_BYTES-1:0] e;
    e = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      e[k] = w[DW+k] ^ (^w[8*k +: 8]);
    end
    return e;
  endfunction
`endif

  logic [MW-1:0]          mem [DEPTH];

  state_t                 state_r;
  state_t                 state_nx;
  logic [ADDR_WIDTH:0]    icnt_r;
  logic [ADDR_WIDTH:0]    icnt_nx;
  logic                   fill_we_s;
  logic                   ready_r;
  logic                   init_done_r;
  logic                   accept_s;

  logic                   wr_en_s;
  logic [ADDR_WIDTH-1:0]  wr_addr_s;
  logic [NUM_BYTES-1:0]   wr_lane_s;
  logic [MW-1:0]          wr_word_s;

  logic                   ack1_r;
  logic [DW-1:0]          dout1_r;
`ifdef RAM_PARITY_EN
  logic [NUM_BYTES-1:0]   perr1_r;
`endif

  // Next-state logic for the init/run sequencer.
  always_comb begin
    state_nx  = state_r;
    icnt_nx   = icnt_r;
    fill_we_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        fill_we_s = 1'b1;
        icnt_nx   = icnt_r + ICNT_ONE;
        if (icnt_r == LAST_ICNT) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_INIT;
        end
      end
      ST_RUN: begin
        state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_INIT;
        icnt_nx  = '0;
      end
    endcase
  end

  // Sequencer state and registered ready / init_done.
  // ready follows the next state, so it rises in the first RUN cycle. This
  // also holds for INIT_FILL=0, where that is the cycle after reset deasserts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= (INIT_FILL != 0) ? ST_INIT : ST_RUN;
      icnt_r      <= '0;
      ready_r     <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      icnt_r      <= icnt_nx;
      ready_r     <= (state_nx == ST_RUN);
      init_done_r <= (state_nx == ST_RUN);
    end
  end

  // A request is accepted only when ready is high. While ready is low, req is dropped.
  always_comb begin
    accept_s = req & ready_r;
  end

  // Write port mux. The init fill and bus writes never overlap, because
  // ready is low for the whole fill.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = addr;
    wr_lane_s = '0;
    wr_word_s = '0;
    if (fill_we_s && !reset) begin
      wr_en_s   = 1'b1;
      wr_addr_s = icnt_r[ADDR_WIDTH-1:0];
      wr_lane_s = '1;
      wr_word_s = encode_word({NUM_BYTES{FILL_BYTE}});
    end else if (accept_s && we) begin
      wr_en_s   = 1'b1;
      wr_addr_s = addr;
      wr_lane_s = be;
      wr_word_s = encode_word(din);
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Memory array. It has no reset, and each lane (with its parity bit) is written on its own.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (wr_lane_s[k]) begin
          mem[wr_addr_s][8*k +: 8] <= wr_word_s[8*k +: 8];
`ifdef RAM_PARITY_EN
          mem[wr_addr_s][DW+k]     <= wr_word_s[DW+k];
`endif
        end
      end
    end
  end

  // First response stage: a synchronous read at the accept edge.
  // dout1_r loads only on reads, so it holds the last read data across write acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack1_r  <= 1'b0;
      dout1_r <= '0;
`ifdef RAM_PARITY_EN
      perr1_r <= '0;
`endif
    end else begin
      ack1_r <= accept_s;
      if (accept_s && !we) begin
        dout1_r <= mem[addr][DW-1:0];
      end else begin
        dout1_r <= dout1_r;
      end
`ifdef RAM_PARITY_EN
      perr1_r <= (accept_s && !we) ? parity_check(mem[addr]) : '0;
`endif
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                 ack2_r;
      logic [DW-1:0]        dout2_r;
`ifdef RAM_PARITY_EN
      logic [NUM_BYTES-1:0] perr2_r;
`endif
      // Extra output stage. It delays ack, data and parity together.
      always_ff @(posedge clk) begin
        if (reset) begin
          ack2_r  <= 1'b0;
          dout2_r <= '0;
`ifdef RAM_PARITY_EN
          perr2_r <= '0;
`endif
        end else begin
          ack2_r  <= ack1_r;
          dout2_r <= dout1_r;
`ifdef RAM_PARITY_EN
          perr2_r <= perr1_r;
`endif
        end
      end
      assign ack  = ack2_r;
      assign dout = dout2_r;
`ifdef RAM_PARITY_EN
      assign parity_err = perr2_r;
`endif
    end else begin : g_no_out_reg
      assign ack  = ack1_r;
      assign dout = dout1_r;
`ifdef RAM_PARITY_EN
      assign parity_err = perr1_r;
`endif
    end
  endgenerate

  assign ready     = ready_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_single_port_ram_multi_byte.sv
// -----------------------------------------------------------------------------
// Testbench for single_port_ram_multi_byte.
// Two instances share one stimulus stream. One has OUT_REG=0 and the other
// OUT_REG=1. Both use a 16-word, 4-lane memory that is zero-filled after reset.
// A word-level array model predicts the response of every accepted request.
// The bench then checks each instance at its own latency.
// -----------------------------------------------------------------------------
module tb_single_port_ram_multi_byte;

  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          we;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [31:0]   din;

  logic          ready0, ack0, init_done0;
  logic [31:0]   dout0;
  logic          ready1, ack1, init_done1;
  logic [31:0]   dout1;
`ifdef RAM_PARITY_EN
  logic [NB-1:0] perr0, perr1;
`endif

  single_port_ram_multi_byte #(
    .ADDR_WIDTH(AW), .NUM_BYTES(NB), .OUT_REG(0), .INIT_FILL(1), .FILL_BYTE(8'h00)
  ) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .ready(ready0), .ack(ack0), .dout(dout0), .init_done(init_done0)
`ifdef RAM_PARITY_EN
    , .parity_err(perr0)
`endif
  );

  single_port_ram_multi_byte #(
    .ADDR_WIDTH(AW), .NUM_BYTES(NB), .OUT_REG(1), .INIT_FILL(1), .FILL_BYTE(8'h00)
  ) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .din(din),
    .ready(ready1), .ack(ack1), .dout(dout1), .init_done(init_done1)
`ifdef RAM_PARITY_EN
    , .parity_err(perr1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        rd;
    logic [31:0] data;
  } resp_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_mem [DEPTH];
  int          busy;
  logic        mready;
  resp_t       prev;
  logic [31:0] hold0;
  logic [31:0] hold1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge. The model applies what the RAM must do at this edge.
  // Both instances are then checked 1 ns later.
  task automatic step();
    resp_t r;
    r = '0;
    @(posedge clk);
    if (reset) begin
      busy   = DEPTH;
      mready = 1'b0;
      prev   = '0;
      hold0  = 32'h0;
      hold1  = 32'h0;
    end else if (!mready) begin
      busy = busy - 1;
      if (busy == 0) begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        mready = 1'b1;
      end
    end else if (req) begin
      r.ack = 1'b1;
      if (we) begin
        for (int k = 0; k < NB; k++)
          if (be[k]) model_mem[addr][8*k +: 8] = din[8*k +: 8];
      end else begin
        r.rd   = 1'b1;
        r.data = model_mem[addr];
      end
    end
    #1;
    check_eq("ready0", {31'h0, ready0}, {31'h0, mready});
    check_eq("init_done0", {31'h0, init_done0}, {31'h0, mready});
    check_eq("ready1", {31'h0, ready1}, {31'h0, mready});
    check_eq("init_done1", {31'h0, init_done1}, {31'h0, mready});
    check_eq("ack0", {31'h0, ack0}, {31'h0, r.ack});
    if (r.rd) hold0 = r.data;
    check_eq("dout0", dout0, hold0);
    check_eq("ack1", {31'h0, ack1}, {31'h0, prev.ack});
    if (prev.rd) hold1 = prev.data;
    check_eq("dout1", dout1, hold1);
    prev = r;
  endtask

  task automatic do_op(input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; din = d;
    step();
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_ops(input int n, input int reset_odds);
    for (int i = 0; i < n; i++) begin
      reset = (reset_odds > 0) && ($urandom_range(0, reset_odds - 1) == 0);
      req   = ($urandom_range(0, 9) < 7);
      we    = $urandom_range(0, 1) == 1;
      be    = 4'($urandom_range(0, 15));
      addr  = 4'($urandom_range(0, 15));
      din   = $urandom;
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 4'h0; din = 32'h0;
    busy = DEPTH; mready = 1'b0; prev = '0; hold0 = 32'h0; hold1 = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset for 2 cycles, then count how long ready stays low.
    step();
    step();
    reset = 1'b0;
    n = 0;
    while (!ready0 && n < 40) begin
      step();
      n++;
    end
    check_eq("init_len", n, 32'd16);

    // After the fill, every word reads back as zero.
    for (int a = 0; a < DEPTH; a++) begin
      do_op(1'b0, 4'h0, 4'(a), 32'h0);
      check_eq("fill_word", dout0, 32'h0);
    end
    idle(2);

    // Partial-lane overwrite.
    do_op(1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
    do_op(1'b1, 4'b0101, 4'd5, 32'h11223344);
    do_op(1'b0, 4'h0, 4'd5, 32'h0);
    check_eq("lanes0", dout0, 32'hDE22BE44);
    idle(1);
    check_eq("lanes1", dout1, 32'hDE22BE44);

    // Read immediately after a write to the same address.
    do_op(1'b1, 4'hF, 4'd3, 32'hA5A5A5A5);
    do_op(1'b0, 4'h0, 4'd3, 32'h0);
    check_eq("raw_ack0", {31'h0, ack0}, 32'd1);
    check_eq("raw_dout0", dout0, 32'hA5A5A5A5);
    idle(1);
    check_eq("raw_ack1", {31'h0, ack1}, 32'd1);
    check_eq("raw_dout1", dout1, 32'hA5A5A5A5);
    idle(1);

    // Four back-to-back reads, then idle cycles to observe dout holding.
    for (int a = 0; a < 4; a++) do_op(1'b0, 4'h0, 4'(a), 32'h0);
    idle(4);

    rand_ops(400, 0);

    // Reset at icnt=7 during the fill, with req held high throughout.
    req = 1'b1; we = 1'b0; addr = 4'd1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    while (!ready0 && n < 40) begin
      step();
      n++;
    end
    check_eq("reinit_len", n, 32'd16);
    idle(2);

    rand_ops(400, 60);
    idle(1);
    if (!mready) begin
      n = 0;
      while (!mready && n < 40) begin
        step();
        n++;
      end
    end

`ifdef RAM_PARITY_EN
    do_op(1'b1, 4'hF, 4'd2, 32'h000000FF);
    idle(2);
    dut0.mem[2][0] = ~dut0.mem[2][0];
    dut1.mem[2][0] = ~dut1.mem[2][0];
    model_mem[2][0] = ~model_mem[2][0];
    do_op(1'b0, 4'h0, 4'd2, 32'h0);
    check_eq("perr0", {28'h0, perr0}, 32'h1);
    do_op(1'b0, 4'h0, 4'd1, 32'h0);
    check_eq("perr1", {28'h0, perr1}, 32'h1);
    check_eq("perr0_clean", {28'h0, perr0}, 32'h0);
    idle(1);
    check_eq("perr1_clean", {28'h0, perr1}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
